// File: rtl/cis_frame_sequencer.sv
// Multi-frame acquisition sequencer: issues fixed-width integration triggers
// to the CIS pattern controller and follows its running status frame by frame.
module cis_frame_sequencer #(
    parameter int TRIG_WIDTH = 10,
    parameter int FRAME_W    = 16,
    parameter int EXP_W      = 24,
    parameter int TMO_W      = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic [EXP_W-1:0]   exposure_cycles,
    input  logic [TMO_W-1:0]   timeout_cycles,
    input  logic               cis_running,
    input  logic               clear_err,
    output logic               integration,
    output logic               busy,
    output logic               frame_done,
    output logic               seq_done,
    output logic               aborted,
    output logic               timeout_err,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int TC_W = $clog2(TRIG_WIDTH);
    localparam logic [TC_W-1:0] TRIG_LAST = TC_W'(TRIG_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RUN,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [TC_W-1:0]    trig_cnt_q, trig_cnt_d;
    logic               run_seen_q, run_seen_d;
    logic [EXP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [FRAME_W-1:0] nfr_q, nfr_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               integration_q, integration_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               seq_done_q, seq_done_d;
    logic               aborted_q, aborted_d;
    logic               timeout_err_q, timeout_err_d;
    logic [FRAME_W-1:0] fcnt_inc;
    logic               tmo_hit;
    logic               tmo_set;

    always_comb begin
        fcnt_inc = (&frame_count_q) ? frame_count_q : frame_count_q + 1'b1;
        tmo_hit  = (tmo_q != '0) && (tmo_cnt_q == tmo_q - 1'b1);
    end

    always_comb begin
        state_d       = state_q;
        trig_cnt_d    = trig_cnt_q;
        run_seen_d    = run_seen_q;
        gap_cnt_d     = gap_cnt_q;
        exp_d         = exp_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_d         = tmo_q;
        nfr_d         = nfr_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        seq_done_d    = 1'b0;
        aborted_d     = 1'b0;
        tmo_set       = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        nfr_d         = num_frames;
                        exp_d         = exposure_cycles;
                        tmo_d         = timeout_cycles;
                        frame_count_d = '0;
                        if (num_frames == '0) begin
                            seq_done_d = 1'b1;
                        end else begin
                            state_d    = TRIG;
                            trig_cnt_d = '0;
                            run_seen_d = 1'b0;
                        end
                    end
                end
                TRIG: begin
                    run_seen_d = run_seen_q | cis_running;
                    if (trig_cnt_q == TRIG_LAST) begin
                        state_d   = run_seen_d ? WAIT_DONE : WAIT_RUN;
                        tmo_cnt_d = '0;
                    end else begin
                        trig_cnt_d = trig_cnt_q + 1'b1;
                    end
                end
                WAIT_RUN: begin
                    if (cis_running) begin
                        state_d   = WAIT_DONE;
                        tmo_cnt_d = '0;
                    end else if (tmo_hit) begin
                        state_d = IDLE;
                        tmo_set = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!cis_running) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = fcnt_inc;
                        if (fcnt_inc == nfr_q) begin
                            seq_done_d = 1'b1;
                            state_d    = IDLE;
                        end else if (exp_q == '0) begin
                            state_d    = TRIG;
                            trig_cnt_d = '0;
                            run_seen_d = 1'b0;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end else if (tmo_hit) begin
                        state_d = IDLE;
                        tmo_set = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == exp_q - 1'b1) begin
                        state_d    = TRIG;
                        trig_cnt_d = '0;
                        run_seen_d = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // a timeout in the same cycle as clear_err must stay visible
        timeout_err_d = tmo_set | (timeout_err_q & ~clear_err);
        integration_d = (state_d == TRIG);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            trig_cnt_q    <= '0;
            run_seen_q    <= 1'b0;
            gap_cnt_q     <= '0;
            exp_q         <= '0;
            tmo_cnt_q     <= '0;
            tmo_q         <= '0;
            nfr_q         <= '0;
            frame_count_q <= '0;
            integration_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_done_q    <= 1'b0;
            aborted_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_cnt_q    <= trig_cnt_d;
            run_seen_q    <= run_seen_d;
            gap_cnt_q     <= gap_cnt_d;
            exp_q         <= exp_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tmo_q         <= tmo_d;
            nfr_q         <= nfr_d;
            frame_count_q <= frame_count_d;
            integration_q <= integration_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            seq_done_q    <= seq_done_d;
            aborted_q     <= aborted_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign integration = integration_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign seq_done    = seq_done_q;
    assign aborted     = aborted_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_count_q;

endmodule
